// File: rtl/gpu_pipelined_divider.sv
// Fully pipelined signed divider: abs/sign stage, BPS-bit restoring stages,
// then sign fix-up, saturation and divide-by-zero/overflow flags.
module gpu_pipelined_divider #(
  parameter int NUM_W    = 32,
  parameter int DEN_W    = 22,
  parameter int QUO_W    = 20,
  parameter int BPS      = 8,
  parameter int TAG_W    = 4,
  parameter int SATURATE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_enable,
  input  logic             i_valid,
  input  logic [NUM_W-1:0] i_numerator,
  input  logic [DEN_W-1:0] i_denominator,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  output logic [QUO_W-1:0] o_quotient,
  output logic [DEN_W-1:0] o_remainder,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_divZero,
  output logic             o_overflow
);

  localparam int S = NUM_W / BPS;

  localparam logic [NUM_W-1:0] QMAG_POS = NUM_W'({(QUO_W-1){1'b1}});
  localparam logic [NUM_W-1:0] QMAG_NEG = QMAG_POS + NUM_W'(1);
  localparam logic [QUO_W-1:0] SAT_POS  = {1'b0, {(QUO_W-1){1'b1}}};
  localparam logic [QUO_W-1:0] SAT_NEG  = {1'b1, {(QUO_W-1){1'b0}}};

  if ((NUM_W % BPS) != 0 || DEN_W > NUM_W || QUO_W > NUM_W) begin : g_bad_params
    $error("gpu_pipelined_divider: illegal parameter combination");
  end

  // Stage k holds partial remainder r and the numerator/quotient shift word q.
  logic             v_q   [0:S];
  logic             v_d   [0:S];
  logic [DEN_W-1:0] r_q   [0:S];
  logic [DEN_W-1:0] r_d   [0:S];
  logic [NUM_W-1:0] q_q   [0:S];
  logic [NUM_W-1:0] q_d   [0:S];
  logic [DEN_W-1:0] d_q   [0:S-1];
  logic [DEN_W-1:0] d_d   [0:S-1];
  logic             sn_q  [0:S];
  logic             sn_d  [0:S];
  logic             neg_q [0:S];
  logic             neg_d [0:S];
  logic             dz_q  [0:S];
  logic             dz_d  [0:S];
  logic [TAG_W-1:0] tag_q [0:S];
  logic [TAG_W-1:0] tag_d [0:S];
  logic [DEN_W-1:0] nlo_q [0:S];
  logic [DEN_W-1:0] nlo_d [0:S];

  logic             out_valid_q, out_valid_d;
  logic [QUO_W-1:0] quo_q, quo_d;
  logic [DEN_W-1:0] rem_q, rem_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             dzf_q, dzf_d;
  logic             ovf_q, ovf_d;

  logic             in_sn;
  logic             in_sd;
  logic [NUM_W-1:0] qm;
  logic [QUO_W-1:0] q_lo;
  logic             ovf_raw;

  function automatic logic [DEN_W+NUM_W-1:0] div_stage(
    input logic [DEN_W-1:0] r_in,
    input logic [NUM_W-1:0] q_in,
    input logic [DEN_W-1:0] d
  );
    logic [DEN_W:0]   rs;
    logic [DEN_W-1:0] r;
    logic [NUM_W-1:0] q;
    r = r_in;
    q = q_in;
    for (int b = 0; b < BPS; b++) begin
      rs = {r, q[NUM_W-1]};
      q  = {q[NUM_W-2:0], 1'b0};
      if (rs >= {1'b0, d}) begin
        rs   = rs - {1'b0, d};
        q[0] = 1'b1;
      end
      r = rs[DEN_W-1:0];
    end
    return {r, q};
  endfunction

  always_comb begin
    v_d   = v_q;
    r_d   = r_q;
    q_d   = q_q;
    d_d   = d_q;
    sn_d  = sn_q;
    neg_d = neg_q;
    dz_d  = dz_q;
    tag_d = tag_q;
    nlo_d = nlo_q;
    in_sn = i_numerator[NUM_W-1];
    in_sd = i_denominator[DEN_W-1];
    if (i_enable) begin
      v_d[0]   = i_valid;
      r_d[0]   = '0;
      q_d[0]   = in_sn ? -i_numerator : i_numerator;
      d_d[0]   = in_sd ? -i_denominator : i_denominator;
      sn_d[0]  = in_sn;
      neg_d[0] = in_sn ^ in_sd;
      dz_d[0]  = (i_denominator == '0);
      tag_d[0] = i_tag;
      nlo_d[0] = i_numerator[DEN_W-1:0];
      for (int k = 1; k <= S; k++) begin
        {r_d[k], q_d[k]} = div_stage(r_q[k-1], q_q[k-1], d_q[k-1]);
        if (k < S) d_d[k] = d_q[k-1];
        v_d[k]   = v_q[k-1];
        sn_d[k]  = sn_q[k-1];
        neg_d[k] = neg_q[k-1];
        dz_d[k]  = dz_q[k-1];
        tag_d[k] = tag_q[k-1];
        nlo_d[k] = nlo_q[k-1];
      end
    end
  end

  // Overflow is judged on the full NUM_W-bit magnitude before truncation.
  always_comb begin
    qm          = q_q[S];
    ovf_raw     = neg_q[S] ? (qm > QMAG_NEG) : (qm > QMAG_POS);
    q_lo        = neg_q[S] ? -qm[QUO_W-1:0] : qm[QUO_W-1:0];
    out_valid_d = out_valid_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    out_tag_d   = out_tag_q;
    dzf_d       = dzf_q;
    ovf_d       = ovf_q;
    if (i_enable) begin
      out_valid_d = v_q[S];
      out_tag_d   = tag_q[S];
      if (dz_q[S]) begin
        quo_d = sn_q[S] ? SAT_NEG : SAT_POS;
        rem_d = nlo_q[S];
        dzf_d = v_q[S];
        ovf_d = 1'b0;
      end else begin
        if (ovf_raw && SATURATE != 0) quo_d = neg_q[S] ? SAT_NEG : SAT_POS;
        else quo_d = q_lo;
        rem_d = sn_q[S] ? -r_q[S] : r_q[S];
        dzf_d = 1'b0;
        ovf_d = v_q[S] & ovf_raw;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k <= S; k++) begin
        v_q[k]   <= 1'b0;
        r_q[k]   <= '0;
        q_q[k]   <= '0;
        sn_q[k]  <= 1'b0;
        neg_q[k] <= 1'b0;
        dz_q[k]  <= 1'b0;
        tag_q[k] <= '0;
        nlo_q[k] <= '0;
      end
      for (int k = 0; k < S; k++) d_q[k] <= '0;
      out_valid_q <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
      out_tag_q   <= '0;
      dzf_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      v_q         <= v_d;
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      sn_q        <= sn_d;
      neg_q       <= neg_d;
      dz_q        <= dz_d;
      tag_q       <= tag_d;
      nlo_q       <= nlo_d;
      out_valid_q <= out_valid_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      out_tag_q   <= out_tag_d;
      dzf_q       <= dzf_d;
      ovf_q       <= ovf_d;
    end
  end

  assign o_valid     = out_valid_q;
  assign o_quotient  = quo_q;
  assign o_remainder = rem_q;
  assign o_tag       = out_tag_q;
  assign o_divZero   = dzf_q;
  assign o_overflow  = ovf_q;

endmodule

// File: doc/gpu_pipelined_divider.md
Name: gpu_pipelined_divider

Overview:
- Parametrised, fully pipelined signed integer divider for GPU setup math (slopes, gradients, UV/RGB deltas).
- Accepts one numerator/denominator pair per enabled cycle and returns quotient and remainder after a fixed latency.
- Adds valid/tag tracking, a global pipeline stall, divide-by-zero and overflow flags, and selectable saturate/truncate output.
- Self-contained RTL with no vendor IP; defaults give a 32/22 -> 20-bit, 6-cycle unit.

Parameters:
NUM_W, 32, numerator width (signed); must be a multiple of BPS
DEN_W, 22, denominator width (signed); DEN_W <= NUM_W
QUO_W, 20, output quotient width (signed); QUO_W <= NUM_W
BPS, 8, quotient bits resolved per iteration stage
TAG_W, 4, width of sideband tag carried alongside each operation
SATURATE, 1, 1 = clamp quotient to QUO_W signed range; 0 = keep low QUO_W bits

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
i_enable  in  1  pipeline advance; 0 freezes every stage, including valids
i_valid  in  1  input operands valid this cycle
i_numerator  in  NUM_W  signed dividend
i_denominator  in  DEN_W  signed divisor
i_tag  in  TAG_W  sideband, returned unchanged with result
o_valid  out  1  result valid
o_quotient  out  QUO_W  signed quotient
o_remainder  out  DEN_W  signed remainder
o_tag  out  TAG_W  tag of this result
o_divZero  out  1  denominator was 0
o_overflow  out  1  true quotient did not fit QUO_W signed

Behaviour:
- Latency is L = NUM_W/BPS + 2 enabled cycles (default 6).
  - Stage 0 registers the absolute values and the signs.
  - Stages 1..NUM_W/BPS perform restoring division, BPS bits per stage, MSB first.
  - The final stage applies sign fix-up, saturation and flags.
- The pipeline is fully pipelined: one new operation is accepted per enabled cycle, with no back-pressure output.
- i_valid with i_enable=0 is ignored; the caller must hold the operands.
- i_enable=0 holds all stage registers and outputs exactly.
  - o_valid stays asserted with unchanged data while stalled.
  - Each result is therefore visible for at least one cycle and for every stalled cycle.
- Results emerge in input order. The tag and flags travel with their operation.
- Magnitudes are handled in NUM_W unsigned bits, so the most-negative numerator works (e.g. -2^31 / -1 = 2^31 internally).
- Division truncates toward zero (C semantics).
  - Remainder sign = numerator sign.
  - |remainder| < |denominator|.
  - Numerator = quotient*denominator + remainder exactly, before any output clamping.
- Overflow: o_overflow=1 when the full-precision quotient lies outside [-2^(QUO_W-1), 2^(QUO_W-1)-1].
  - SATURATE=1: o_quotient is clamped to that bound, with sign taken from the true quotient.
  - SATURATE=0: o_quotient is the low QUO_W bits of the true quotient.
  - The remainder is unaffected in both modes.
- Divide by zero:
  - o_divZero=1 and o_overflow=0.
  - o_quotient = 2^(QUO_W-1)-1 if numerator >= 0, else -2^(QUO_W-1), in both modes.
  - o_remainder = low DEN_W bits of the numerator.
- Flags are meaningful only when o_valid=1; outside that they are don't-care and zero is recommended.
- Reset values:
  - All stage valid bits are 0.
  - o_valid, o_quotient, o_remainder, o_tag, o_divZero and o_overflow are all 0.
  - Internal data registers may stay unreset.
- Reset mid-operation discards all in-flight operations; no result appears for them after reset deasserts.
- Operands presented in the first enabled cycle after reset deassertion are accepted normally.
- Parameter legality (NUM_W % BPS == 0, DEN_W <= NUM_W, QUO_W <= NUM_W) is checked in simulation via an elaboration-time error.

Test Plan:
- Basic signed: at defaults, apply -1000/7 with tag 3 and i_enable=1 -> exactly 6 cycles later o_valid=1, quotient -142, remainder -6, tag 3, both flags 0.
- Overflow: apply 0x7FFFFFFF/1.
  - SATURATE=1 -> quotient 0x7FFFF, o_overflow=1, remainder 0.
  - SATURATE=0 -> quotient 0xFFFFF, o_overflow=1.
  - Also apply -2^31 / -1 -> no internal wrap; saturates to 0x7FFFF.
- Divide by zero: 100/0 -> quotient 0x7FFFF, remainder 100, o_divZero=1. -5/0 -> quotient 0x80000 (i.e. -2^19), remainder -5.
- Stall: issue A=50/5, B=-9/2 back to back, then hold i_enable=0 for 3 cycles while A and B are in flight.
  - A appears 9 cycles after issue with quotient 10.
  - B appears in the next enabled cycle with quotient -4 and remainder -1.
  - Outputs hold steady while stalled.
- Reset mid-flight: issue 4 operations, assert reset for 1 cycle after the second clock -> o_valid stays 0 until operations issued after reset arrive at latency 6.
- Stream: 1000 random back-to-back operations (including denominator ±1, ±max, and the most-negative numerator) with random i_enable gaps -> every result and tag matches the C-truncation reference model, in order.
